// File: rtl/ammo_pkg.sv
// ammo_pkg: shared types and screen constants for the ammo controller.
//   ammo_state_t : controller state encoding (IDLE, FLYING, COOLDOWN)
//   Y_MIN, Y_MAX : playable vertical range, shared with the obstacle block
//   COORD_W      : width of screen coordinates on the ammo bus
package ammo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } ammo_state_t;

  localparam int unsigned Y_MIN   = 3;
  localparam int unsigned Y_MAX   = 479;
  localparam int unsigned COORD_W = 10;

endpackage

// File: rtl/ammo_if.sv
// ammo_if: signals between the ammo controller, the keyboard/ship path and
// the obstacle block.
//   fire, ship_x/y/size, bullet_hit          : inputs to the controller
//   ball_ammo_x/y/size, ammo_active, hit_count : controller outputs
// modport master : the ammo controller
// modport slave  : everything around it (ship, keyboard, obstacle block)
interface ammo_if;

  logic        fire;
  logic [9:0]  ship_x;
  logic [9:0]  ship_y;
  logic [9:0]  ship_size;
  logic        bullet_hit;
  logic [9:0]  ball_ammo_x;
  logic [9:0]  ball_ammo_y;
  logic [9:0]  ball_ammo_size;
  logic        ammo_active;
  logic [15:0] hit_count;

  modport master (
    input  fire, ship_x, ship_y, ship_size, bullet_hit,
    output ball_ammo_x, ball_ammo_y, ball_ammo_size, ammo_active, hit_count
  );

  modport slave (
    output fire, ship_x, ship_y, ship_size, bullet_hit,
    input  ball_ammo_x, ball_ammo_y, ball_ammo_size, ammo_active, hit_count
  );

endinterface

// File: rtl/ammo_cooldown_timer.sv
// ammo_cooldown_timer: load/decrement counter for the post-retire lockout.
//   frame_clk, Reset : frame clock, asynchronous active-high reset
//   load, load_val   : load the counter (has priority over dec)
//   dec              : decrement this frame (saturates at 0)
//   expire           : this decrement brings the counter to zero
module ammo_cooldown_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Flagged on the decrement that reaches zero, so the owner can leave the
  // lockout on that same edge rather than one frame later.
  assign expire = dec && (cnt_q <= WIDTH'(1));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ammo_controller.sv
// ammo_controller: single-shot projectile controller.
// Launches one ammo ball from the ship on a fire key edge, moves it up
// AMMO_SPEED pixels per frame, and retires it on an obstacle hit or at the
// top of the screen. A retired ball is parked at (0,0).
//   Reset     : asynchronous, active-high
//   frame_clk : one rising edge per video frame
//   bus       : ammo_if.master (fire/ship inputs, bullet_hit, ammo bus out)
// Optional feature: define AMMO_COOLDOWN_EN to add a COOLDOWN_FRAMES lockout
// after each retire (COOLDOWN state + ammo_cooldown_timer).
module ammo_controller
  import ammo_pkg::*;
#(
  parameter int unsigned AMMO_SIZE       = 4,
  parameter int unsigned AMMO_SPEED      = 4,
  parameter int unsigned Y_MIN           = ammo_pkg::Y_MIN,
  parameter int unsigned COOLDOWN_FRAMES = 15
) (
  input  logic    Reset,
  input  logic    frame_clk,
  ammo_if.master  bus
);

  localparam logic [9:0] SPAWN_MIN = 10'(Y_MIN + AMMO_SIZE);
  localparam logic [9:0] TOP_LIMIT = 10'(Y_MIN + AMMO_SIZE + AMMO_SPEED);
  localparam logic [9:0] STEP      = 10'(AMMO_SPEED);

  ammo_state_t state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        active_q, active_d;
  logic [15:0] hit_q, hit_d;
  logic        fire_prev_q, fire_prev_d;

  logic [9:0]  spawn_y;
  logic        fire_edge;
  logic        retire;

`ifdef AMMO_COOLDOWN_EN
  localparam int unsigned CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

  logic cd_load;
  logic cd_dec;
  logic cd_expire;

  ammo_cooldown_timer #(
    .WIDTH (CD_W)
  ) u_cooldown (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (cd_load),
    .load_val  (CD_W'(COOLDOWN_FRAMES - 1)),
    .dec       (cd_dec),
    .expire    (cd_expire)
  );
`endif

  // ship_y >= ship_size is guaranteed by the ship path, so no wrap here.
  assign spawn_y   = bus.ship_y - bus.ship_size;
  assign fire_edge = bus.fire & ~fire_prev_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    active_d    = active_q;
    hit_d       = hit_q;
    fire_prev_d = bus.fire;
    retire      = 1'b0;
`ifdef AMMO_COOLDOWN_EN
    cd_load     = 1'b0;
    cd_dec      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (fire_edge && (spawn_y > SPAWN_MIN)) begin
          x_d      = bus.ship_x;
          y_d      = spawn_y;
          active_d = 1'b1;
          state_d  = FLYING;
        end
      end
      FLYING: begin
        // A hit wins over the top-of-screen check in the same frame.
        if (bus.bullet_hit) begin
          retire = 1'b1;
          hit_d  = hit_q + 16'd1;
        end else if (y_q <= TOP_LIMIT) begin
          retire = 1'b1;
        end else begin
          y_d = y_q - STEP;
        end
      end
      COOLDOWN: begin
`ifdef AMMO_COOLDOWN_EN
        cd_dec = 1'b1;
        if (cd_expire) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      active_d = 1'b0;
      x_d      = '0;
      y_d      = '0;
`ifdef AMMO_COOLDOWN_EN
      // A one-frame lockout is already covered by the retire edge itself.
      if (COOLDOWN_FRAMES > 1) begin
        state_d = COOLDOWN;
        cd_load = 1'b1;
      end else begin
        state_d = IDLE;
      end
`else
      state_d = IDLE;
`endif
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      active_q    <= 1'b0;
      hit_q       <= '0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      active_q    <= active_d;
      hit_q       <= hit_d;
      fire_prev_q <= fire_prev_d;
    end
  end

  assign bus.ball_ammo_x    = x_q;
  assign bus.ball_ammo_y    = y_q;
  assign bus.ball_ammo_size = 10'(AMMO_SIZE);
  assign bus.ammo_active    = active_q;
  assign bus.hit_count      = hit_q;

endmodule
